// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Sequencing controller for the 4-stage vector ASIP pipeline
// (fetch, decode, execute, writeback/memory).
//
// It tracks in-flight register writes in a per-register scoreboard and
// stalls decode on read-after-write hazards, because the pipeline has no
// forwarding. It also holds fetch while a PC-writing instruction resolves,
// and flushes the wrong-path instruction when that branch is taken.
//
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   dec_valid                   decode stage holds a real instruction
//   dec_rs1/2, _en, _vec        source selects, read enables, space (1 = vector)
//   dec_rd, dec_wr_sc/_vec      destination select and scalar/vector write enables
//   dec_pc_wr                   decoded instruction may write the PC
//   br_taken                    PC write enable at the writeback stage
//   stall_f                     hold PC and the fetch/decode pipe
//   bubble_de                   insert a NOP into the decode/execute pipe
//   flush_fd                    clear the fetch/decode pipe (one cycle)
//   busy                        scoreboard non-empty or state != RUN
//   state                       00 RUN, 01 BR_WAIT, 10 REFILL
//   err                         sticky: br_taken seen outside BR_WAIT
module pipeline_hazard_ctrl #(
    parameter int SEL_BITS = 4,
    parameter int WB_LAT   = 3,
    parameter int BR_LAT   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [SEL_BITS-1:0] dec_rs1,
    input  logic [SEL_BITS-1:0] dec_rs2,
    input  logic                dec_rs1_en,
    input  logic                dec_rs2_en,
    input  logic                dec_rs1_vec,
    input  logic                dec_rs2_vec,
    input  logic [SEL_BITS-1:0] dec_rd,
    input  logic                dec_wr_sc,
    input  logic                dec_wr_vec,
    input  logic                dec_pc_wr,
    input  logic                br_taken,
    output logic                stall_f,
    output logic                bubble_de,
    output logic                flush_fd,
    output logic                busy,
    output logic [1:0]          state,
    output logic                err
);

    localparam int NREG = 1 << SEL_BITS;
    localparam int CW   = (WB_LAT < 1) ? 1 : $clog2(WB_LAT + 1);
    localparam int BW   = (BR_LAT < 1) ? 1 : $clog2(BR_LAT + 1);

    localparam logic [CW-1:0] WB_LOAD = CW'(WB_LAT);
    localparam logic [BW-1:0] BR_LOAD = BW'(BR_LAT);

    localparam logic [1:0] RUN     = 2'b00;
    localparam logic [1:0] BR_WAIT = 2'b01;
    localparam logic [1:0] REFILL  = 2'b10;

    logic [CW-1:0]   cnt_sc  [NREG];
    logic [CW-1:0]   cnt_vec [NREG];
    logic [NREG-1:0] pend_sc;
    logic [NREG-1:0] pend_vec;
    logic [BW-1:0]   br_cnt;
    logic [BW-1:0]   br_cnt_nxt;
    logic [1:0]      state_nxt;
    logic            rs1_pend;
    logic            rs2_pend;
    logic            haz;
    logic            issue;

    always_comb begin
        pend_sc  = '0;
        pend_vec = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_sc[i]  = (cnt_sc[i]  != '0);
            pend_vec[i] = (cnt_vec[i] != '0);
        end
    end

    assign rs1_pend = dec_rs1_vec ? pend_vec[dec_rs1] : pend_sc[dec_rs1];
    assign rs2_pend = dec_rs2_vec ? pend_vec[dec_rs2] : pend_sc[dec_rs2];

    // The hazard is evaluated in every state; it only blocks issue in RUN,
    // and outside RUN the FSM stalls decode by itself.
    assign haz   = dec_valid & ((dec_rs1_en & rs1_pend) | (dec_rs2_en & rs2_pend));
    assign issue = dec_valid & (state == RUN) & ~haz;

    // Scoreboard: a load on issue takes priority over the per-cycle decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_sc[i]  <= '0;
                cnt_vec[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (issue && dec_wr_sc && (dec_rd == SEL_BITS'(i)))
                    cnt_sc[i] <= WB_LOAD;
                else if (cnt_sc[i] != '0)
                    cnt_sc[i] <= cnt_sc[i] - 1'b1;

                if (issue && dec_wr_vec && (dec_rd == SEL_BITS'(i)))
                    cnt_vec[i] <= WB_LOAD;
                else if (cnt_vec[i] != '0)
                    cnt_vec[i] <= cnt_vec[i] - 1'b1;
            end
        end
    end

    // Branch FSM. BR_WAIT leaves on the cycle br_cnt would reach zero, so a
    // not-taken branch occupies exactly BR_LAT cycles in BR_WAIT.
    always_comb begin
        state_nxt  = state;
        br_cnt_nxt = br_cnt;
        case (state)
            RUN: begin
                if (issue && dec_pc_wr) begin
                    state_nxt  = BR_WAIT;
                    br_cnt_nxt = BR_LOAD;
                end
            end
            BR_WAIT: begin
                if (br_taken) begin
                    state_nxt  = REFILL;
                    br_cnt_nxt = '0;
                end else if (br_cnt <= BW'(1)) begin
                    state_nxt  = RUN;
                    br_cnt_nxt = '0;
                end else begin
                    br_cnt_nxt = br_cnt - 1'b1;
                end
            end
            REFILL: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt  = RUN;
                br_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            br_cnt <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            br_cnt <= br_cnt_nxt;
            if (br_taken && (state != BR_WAIT))
                err <= 1'b1;
        end
    end

    // REFILL lets fetch run from the new PC but still bubbles decode, since
    // the fetch/decode pipe was just cleared.
    assign stall_f   = ((state == RUN) & haz) | (state == BR_WAIT);
    assign bubble_de = ((state == RUN) & haz) | (state == BR_WAIT) | (state == REFILL);
    assign flush_fd  = (state == BR_WAIT) & br_taken;
    assign busy      = (|pend_sc) | (|pend_vec) | (state != RUN);

endmodule
